// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared stall encodings, stall bit indices and madd phase values
package pipe_stall_ctrl_pkg;

    // Bit positions inside the stall vector; a 1 holds that register.
    localparam int STALL_BIT_PC    = 0;
    localparam int STALL_BIT_IF_ID = 1;
    localparam int STALL_BIT_ID_EX = 2;
    localparam int STALL_BIT_EX_MEM = 3;
    localparam int STALL_BIT_MEM_WB = 4;
    localparam int STALL_BIT_WB    = 5;
    localparam int STALL_W         = 6;

    // ID stall freezes the front end up to ID/EX; EX stall also freezes EX/MEM input.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    // madd/msub phase presented to EX.
    localparam logic [1:0] CNT_MUL = 2'd0;
    localparam logic [1:0] CNT_ACC = 2'd1;

endpackage

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush sequencer with madd and div watchdog
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DIV_MAX_CYCLES = 34,
    parameter int CNT_W          = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               ex_op_madd,
    input  logic               ex_op_div,
    input  logic               div_ready,
    input  logic               flush_req,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [1:0]         cnt,
    output logic               div_start,
    output logic               div_annul,
    output logic               busy,
    output logic               div_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MADD = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // Last DIV cycle that may still wait for div_ready before the watchdog fires.
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_MAX_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             flush_q, flush_d;
    logic             div_annul_q, div_annul_d;
    logic             div_timeout_q, div_timeout_d;
    logic             hold_ex;
    logic             start_c;

    // Next-state, counter and EX-hold decision; flush_req overrides any op in flight.
    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        flush_d       = flush_req;
        div_annul_d   = 1'b0;
        div_timeout_d = 1'b0;
        hold_ex       = 1'b0;
        start_c       = 1'b0;
        if (flush_req) begin
            state_d     = ST_IDLE;
            div_cnt_d   = '0;
            div_annul_d = (state_q == ST_DIV);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ex_op_div) begin
                        start_c   = 1'b1;
                        hold_ex   = 1'b1;
                        div_cnt_d = '0;
                        state_d   = ST_DIV;
                    end else if (ex_op_madd) begin
                        hold_ex = 1'b1;
                        state_d = ST_MADD;
                    end
                end
                ST_MADD: begin
                    state_d = ST_IDLE;
                end
                ST_DIV: begin
                    start_c = 1'b1;
                    if (div_ready) begin
                        // A result on the watchdog cycle still counts as success.
                        state_d   = ST_IDLE;
                        div_cnt_d = '0;
                    end else if (div_cnt_q == DIV_LAST) begin
                        state_d       = ST_IDLE;
                        div_cnt_d     = '0;
                        div_annul_d   = 1'b1;
                        div_timeout_d = 1'b1;
                    end else begin
                        hold_ex   = 1'b1;
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    div_cnt_d = '0;
                end
            endcase
        end
    end

    // State, watchdog counter and the one-cycle pulse outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            div_cnt_q     <= '0;
            flush_q       <= 1'b0;
            div_annul_q   <= 1'b0;
            div_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            flush_q       <= flush_d;
            div_annul_q   <= div_annul_d;
            div_timeout_q <= div_timeout_d;
        end
    end

    // Same-cycle outputs; gated by reset so nothing leaks while the core is held.
    always_comb begin
        stall     = STALL_NONE;
        div_start = 1'b0;
        if (rst) begin
            div_start = start_c;
            if (flush_req)        stall = STALL_NONE;
            else if (hold_ex)     stall = STALL_EX;
            else if (stallreq_id) stall = STALL_ID;
            else                  stall = STALL_NONE;
        end
    end

    assign cnt         = (state_q == ST_MADD) ? CNT_ACC : CNT_MUL;
    assign busy        = (state_q != ST_IDLE);
    assign flush       = flush_q;
    assign div_annul   = div_annul_q;
    assign div_timeout = div_timeout_q;

endmodule
